// File: rtl/spmm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spmm_pkg
//  Description : Shared defaults, lane type and ceil-log2 helper for the
//                segmented reduction unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package spmm_pkg;

  localparam int c_default_n = 16;  // lane count
  localparam int c_default_w = 8;   // element width in bits

  // One lane operand at the default element width
  typedef logic [c_default_w-1:0] lane_t;

  // Ceiling log2 for elaboration-time sizing (value >= 1)
  function automatic int spmm_clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg_scan_stage.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan_stage
//  Description : One registered step of a segmented Hillis-Steele scan at
//                lane distance D. A lane j >= D whose flag is clear absorbs
//                the value and flag of lane j-D; every other lane passes.
//                Build option: SEG_RED_SAT_EN selects unsigned saturating
//                addition instead of modulo-2^W wrap.
//  Revision    : 1.0 - initial release
//  Ports       : clock, reset   - clock, async active-high reset
//                advance        - stage load enable (global pipeline move)
//                in_valid/data/flag/idx   - previous stage contents
//                out_valid/data/flag/idx  - registered stage contents
// ============================================================================
module seg_scan_stage
  import spmm_pkg::*;
#(
  parameter int N   = c_default_n,
  parameter int W   = c_default_w,
  parameter int LGN = spmm_clog2(N),
  parameter int D   = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    advance,
  input  logic                    in_valid,
  input  logic [N-1:0][W-1:0]     in_data,
  input  logic [N-1:0]            in_flag,
  input  logic [N-1:0][LGN-1:0]   in_idx,
  output logic                    out_valid,
  output logic [N-1:0][W-1:0]     out_data,
  output logic [N-1:0]            out_flag,
  output logic [N-1:0][LGN-1:0]   out_idx
);

  function automatic logic [W-1:0] lane_add(input logic [W-1:0] a,
                                            input logic [W-1:0] b);
`ifdef SEG_RED_SAT_EN
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[W] ? {W{1'b1}} : s[W-1:0];
`else
    return a + b;
`endif
  endfunction

  logic [N-1:0][W-1:0] w_data;
  logic [N-1:0]        w_flag;

  // A set flag means the lane's window already reaches its segment head,
  // so it must not accumulate anything further to its left.
  always_comb begin
    w_data = in_data;
    w_flag = in_flag;
    for (int j = D; j < N; j++) begin
      if (!in_flag[j]) begin
        w_data[j] = lane_add(in_data[j], in_data[j-D]);
        w_flag[j] = in_flag[j] | in_flag[j-D];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_flag  <= '0;
      out_idx   <= '0;
    end else if (advance) begin
      out_valid <= in_valid;
      out_data  <= w_data;
      out_flag  <= w_flag;
      out_idx   <= in_idx;
    end
  end

endmodule
`default_nettype wire

// File: rtl/seg_red_unit.sv
`default_nettype none
// ============================================================================
//  Module      : seg_red_unit
//  Description : Pipelined segmented reduction. LGN scan stages compute the
//                segmented inclusive prefix sum, then a gather stage picks
//                out_data[i] = scan[out_idx[i]]. Latency LGN+1, one vector
//                per cycle, whole pipeline stalls on output backpressure.
//                Build option: SEG_RED_SAT_EN (saturating sums).
//  Revision    : 1.0 - initial release
//  Ports       : clock, reset           - clock, async active-high reset
//                in_valid / in_ready    - input handshake
//                data, split, out_idx   - lane operands, segment ends, gather
//                out_valid / out_ready  - output handshake
//                out_data               - gathered segment sums
//                occupancy              - vectors in flight (0..LGN+1)
// ============================================================================
module seg_red_unit
  import spmm_pkg::*;
#(
  parameter  int N   = c_default_n,
  parameter  int W   = c_default_w,
  localparam int LGN = spmm_clog2(N)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N-1:0][W-1:0]     data,
  input  logic [N-1:0]            split,
  input  logic [N-1:0][LGN-1:0]   out_idx,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N-1:0][W-1:0]     out_data,
  output logic [LGN+1:0]          occupancy
);

  logic                  w_advance;
  logic                  w_accept;
  logic                  w_drain;
  logic                  w_valid [0:LGN];
  logic [N-1:0][W-1:0]   w_vec   [0:LGN];
  logic [N-1:0]          w_flag  [0:LGN];
  logic [N-1:0][LGN-1:0] w_idx   [0:LGN];
  logic                  w_unused_bits;

  logic                  r_out_valid;
  logic [N-1:0][W-1:0]   r_out_data;
  logic [LGN+1:0]        r_occupancy;

  assign w_advance = !r_out_valid || out_ready;
  assign w_accept  = in_valid && w_advance;
  assign w_drain   = r_out_valid && out_ready;

  // Stage-0 view of the input: lane j heads a segment when the previous
  // lane closed one. split[N-1] only closes the final segment, which the
  // vector boundary closes anyway; the final flags are not needed either.
  assign w_valid[0] = in_valid;
  assign w_vec[0]   = data;
  assign w_flag[0]  = {split[N-2:0], 1'b1};
  assign w_idx[0]   = out_idx;
  assign w_unused_bits = ^{split[N-1], w_flag[LGN]};

  generate
    for (genvar k = 0; k < LGN; k++) begin : g_stage
      seg_scan_stage #(
        .N   (N),
        .W   (W),
        .LGN (LGN),
        .D   (1 << k)
      ) u_stage (
        .clock     (clock),
        .reset     (reset),
        .advance   (w_advance),
        .in_valid  (w_valid[k]),
        .in_data   (w_vec[k]),
        .in_flag   (w_flag[k]),
        .in_idx    (w_idx[k]),
        .out_valid (w_valid[k+1]),
        .out_data  (w_vec[k+1]),
        .out_flag  (w_flag[k+1]),
        .out_idx   (w_idx[k+1])
      );
    end
  endgenerate

  // Gather stage doubles as the output register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_advance) begin
      r_out_valid <= w_valid[LGN];
      for (int i = 0; i < N; i++) begin
        r_out_data[i] <= w_vec[LGN][w_idx[LGN][i]];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_occupancy <= '0;
    end else if (w_accept && !w_drain) begin
      r_occupancy <= r_occupancy + {{(LGN+1){1'b0}}, 1'b1};
    end else if (!w_accept && w_drain) begin
      r_occupancy <= r_occupancy - {{(LGN+1){1'b0}}, 1'b1};
    end
  end

  assign in_ready  = w_advance;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign occupancy = r_occupancy;

endmodule
`default_nettype wire

// File: tb/tb_seg_red_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg_red_unit
//  Description : Self-checking bench for seg_red_unit at N=4, W=8. Directed
//                table vectors, stall and reset sequences, then random
//                streaming against a plain-arithmetic reference model.
//                Honours SEG_RED_SAT_EN for the expected sums.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_red_unit;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int LGN = 2;

  typedef logic [N-1:0][W-1:0]   vec_t;
  typedef logic [N-1:0][LGN-1:0] idx_t;
  typedef struct {
    vec_t            d;
    logic [N-1:0]    s;
    idx_t            ix;
    vec_t            e;
  } vec_rec_t;

  logic             clock;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  vec_t             data;
  logic [N-1:0]     split;
  idx_t             out_idx;
  logic             out_valid;
  logic             out_ready;
  vec_t             out_data;
  logic [LGN+1:0]   occupancy;

  seg_red_unit #(.N(N), .W(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data      (data),
    .split     (split),
    .out_idx   (out_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_drain  = 0;
  int   peak     = 0;
  logic last_acc = 1'b0;
  vec_t q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
  endtask

  function automatic vec_t mkv(input int a0, input int a1, input int a2, input int a3);
    vec_t v;
    v[0] = 8'(a0); v[1] = 8'(a1); v[2] = 8'(a2); v[3] = 8'(a3);
    return v;
  endfunction

  function automatic idx_t mki(input int a0, input int a1, input int a2, input int a3);
    idx_t v;
    v[0] = 2'(a0); v[1] = 2'(a1); v[2] = 2'(a2); v[3] = 2'(a3);
    return v;
  endfunction

  // Reference: each lane sums its segment from the head up to itself.
  function automatic vec_t model(input vec_t d, input logic [N-1:0] s, input idx_t ix);
    int   scan [N];
    int   st;
    int   sum;
    vec_t r;
    for (int j = 0; j < N; j++) begin
      st = j;
      while (st > 0 && !s[st-1]) st--;
      sum = 0;
      for (int k = st; k <= j; k++) sum += int'(d[k]);
`ifdef SEG_RED_SAT_EN
      scan[j] = (sum > 255) ? 255 : sum;
`else
      scan[j] = sum % 256;
`endif
    end
    for (int i = 0; i < N; i++) r[i] = 8'(scan[int'(ix[i])]);
    return r;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int i = 0; i < N; i++)
      v[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 40));
    return v;
  endfunction

  // One clock: called at a negedge with inputs already driven.
  task automatic step();
    logic acc, drn, hold;
    vec_t held, want;
    #1;
    acc  = in_valid && in_ready;
    drn  = out_valid && out_ready;
    hold = out_valid && !out_ready;
    held = out_data;
    if (drn) begin
      n_drain++;
      chk("output_expected", 64'(q.size() > 0), 64'd1);
      if (q.size() > 0) begin
        want = q.pop_front();
        chk("scoreboard_data", 64'(out_data), 64'(want));
      end
    end
    if (acc) q.push_back(model(data, split, out_idx));
    @(posedge clock);
    @(negedge clock);
    chk("occupancy", 64'(occupancy), 64'(q.size()));
    if (int'(occupancy) > peak) peak = int'(occupancy);
    if (hold) begin
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_data", 64'(out_data), 64'(held));
    end
    last_acc = acc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  vec_rec_t tbl [5];
  vec_rec_t sv  [5];
  int       p, stall_left, drain0;
  logic     first_seen;

  initial begin
    tbl[0] = '{mkv(1,2,3,4),   4'b1010, mki(1,3,0,0), mkv(3,7,1,1)};
    tbl[1] = '{mkv(9,8,7,6),   4'b1111, mki(0,1,2,3), mkv(9,8,7,6)};
    tbl[2] = '{mkv(1,2,3,4),   4'b0000, mki(3,3,3,3), mkv(10,10,10,10)};
`ifdef SEG_RED_SAT_EN
    tbl[3] = '{mkv(200,100,0,0), 4'b0000, mki(3,3,3,3), mkv(255,255,255,255)};
`else
    tbl[3] = '{mkv(200,100,0,0), 4'b0000, mki(3,3,3,3), mkv(44,44,44,44)};
`endif
    tbl[4] = '{mkv(5,6,7,8),   4'b0000, mki(3,2,1,0), mkv(26,18,11,5)};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    data = '0; split = '0; out_idx = '0;
    repeat (2) @(negedge clock);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_in_ready",  64'(in_ready),  64'd1);
    chk("reset_occupancy", 64'(occupancy), 64'd0);
    chk("reset_out_data",  64'(out_data),  64'd0);
    reset = 1'b0;
    @(negedge clock);

    // Directed vectors, one at a time, exact latency
    for (int t = 0; t < 5; t++) begin
      data = tbl[t].d; split = tbl[t].s; out_idx = tbl[t].ix;
      in_valid = 1'b1; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      data = rand_vec(); out_idx = idx_t'($urandom);  // idx must travel with data
      chk($sformatf("table%0d_lat1", t), 64'(out_valid), 64'd0);
      step();
      chk($sformatf("table%0d_lat2", t), 64'(out_valid), 64'd0);
      step();
      chk($sformatf("table%0d_valid", t), 64'(out_valid), 64'd1);
      chk($sformatf("table%0d_data", t), 64'(out_data), 64'(tbl[t].e));
      step();
      chk($sformatf("table%0d_drained", t), 64'(out_valid), 64'd0);
    end

    // Five back-to-back vectors, 3-cycle stall on the first result
    for (int i = 0; i < 5; i++) sv[i] = '{rand_vec(), 4'($urandom), idx_t'($urandom), '0};
    p = 0; first_seen = 1'b0; stall_left = 0; peak = 0; drain0 = n_drain;
    for (int c = 0; c < 20; c++) begin
      if (p < 5) begin
        data = sv[p].d; split = sv[p].s; out_idx = sv[p].ix; in_valid = 1'b1;
      end else in_valid = 1'b0;
      if (out_valid && !first_seen) begin first_seen = 1'b1; stall_left = 3; end
      out_ready = (stall_left == 0);
      if (stall_left > 0) begin
        #1 chk("stall_in_ready", 64'(in_ready), 64'd0);
        stall_left--;
      end
      step();
      if (last_acc) p++;
    end
    chk("stall_all_accepted", 64'(p), 64'd5);
    chk("stall_drained_count", 64'(n_drain - drain0), 64'd5);
    chk("stall_peak_occupancy", 64'(peak), 64'd3);

    // Reset while two vectors are in flight
    out_ready = 1'b1; in_valid = 1'b1;
    data = rand_vec(); split = 4'($urandom); out_idx = idx_t'($urandom);
    step();
    data = rand_vec();
    step();
    in_valid = 1'b0;
    #2 reset = 1'b1;
    q.delete();
    #1 chk("async_reset_occupancy", 64'(occupancy), 64'd0);
    chk("async_reset_valid", 64'(out_valid), 64'd0);
    @(posedge clock); @(negedge clock);
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      chk("post_reset_no_output", 64'(out_valid), 64'd0);
    end

    // Random streaming with random backpressure
    in_valid = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!in_valid || last_acc) begin
        in_valid = ($urandom_range(0, 9) < 7);
        data     = rand_vec();
        split    = 4'($urandom);
        out_idx  = idx_t'($urandom);
      end
      out_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) step();
    chk("final_queue_empty", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
